// File: rtl/rv32i_data_responder_pkg.sv
// Shared address map and decode helper for the CPU data-side responder.
package rv32i_data_responder_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_LED   = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_SW    = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_TCNT  = 32'hFFFF_0010;
  localparam logic [31:0] ADDR_TCMP  = 32'hFFFF_0014;
  localparam logic [31:0] ADDR_TSTAT = 32'hFFFF_0018;

  typedef enum logic [2:0] {
    T_RAM,
    T_LED,
    T_SW,
    T_TCNT,
    T_TCMP,
    T_TSTAT,
    T_NONE
  } target_e;

  // Maps a byte address to its target; the two low address bits never matter.
  function automatic target_e decodeAddr(input logic [31:0] addr, input int unsigned ramWords);
    target_e    result;
    logic [31:0] wordIdx;
    logic [31:0] wordAddr;
    wordIdx  = {2'b00, addr[31:2]};
    wordAddr = {addr[31:2], 2'b00};
    result   = T_NONE;
    if (wordIdx < ramWords) begin
      result = T_RAM;
    end else begin
      case (wordAddr)
        ADDR_LED:   result = T_LED;
        ADDR_SW:    result = T_SW;
        ADDR_TCNT:  result = T_TCNT;
        ADDR_TCMP:  result = T_TCMP;
        ADDR_TSTAT: result = T_TSTAT;
        default:    result = T_NONE;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/rv32i_mmio_timer.sv
// Prescaled 32-bit timer with compare register and sticky match flag.
module rv32i_mmio_timer
  import rv32i_data_responder_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tcntWe_i,
  input  logic        tcmpWe_i,
  input  logic        tstatWe_i,
  input  logic [31:0] wdata_i,
  input  target_e     rdSel_i,
  output logic [31:0] rdata_o,
  output logic        flag_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [31:0]   tcnt_q, tcnt_d;
  logic [31:0]   tcmp_q, tcmp_d;
  logic          pend_q, pend_d;
  logic          flag_q, flag_d;
  logic          tick;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  // Next-state: a CPU count write beats the tick and restarts the prescaler; the match is
  // remembered for one clock so the flag rises the clock after the counting tick.
  always_comb begin
    pre_d  = pre_q;
    tcnt_d = tcnt_q;
    tcmp_d = tcmp_q;
    pend_d = 1'b0;
    flag_d = flag_q;
    if (tcntWe_i) begin
      pre_d  = '0;
      tcnt_d = wdata_i;
    end else if (tick) begin
      pre_d  = '0;
      tcnt_d = tcnt_q + 32'd1;
    end else begin
      pre_d  = pre_q + PW'(1);
    end
    if (tcmpWe_i) begin
      tcmp_d = wdata_i;
    end
    pend_d = tick && !tcntWe_i && ((tcnt_q + 32'd1) == tcmp_d);
    if (pend_q) begin
      flag_d = 1'b1;
    end else if (tstatWe_i && wdata_i[0]) begin
      flag_d = 1'b0;
    end
  end

  // Timer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      tcnt_q <= 32'h0000_0000;
      tcmp_q <= 32'hFFFF_FFFF;
      pend_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      pend_q <= pend_d;
      flag_q <= flag_d;
    end
  end

  // Read mux for the timer registers; anything else reads zero here.
  always_comb begin
    rdata_o = 32'h0000_0000;
    case (rdSel_i)
      T_TCNT:  rdata_o = tcnt_q;
      T_TCMP:  rdata_o = tcmp_q;
      T_TSTAT: rdata_o = {31'b0, flag_q};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/rv32i_data_responder.sv
// CPU data-memory responder: word RAM plus LED, switch and timer MMIO registers.
module rv32i_data_responder
  import rv32i_data_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 2048,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned N_LED     = 10,
  parameter int unsigned N_SW      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Memwrite,
  input  logic [31:0]      Memaddr,
  input  logic [31:0]      MemWdata,
  output logic [31:0]      MemRdata,
  input  logic [N_SW-1:0]  sw,
  output logic [N_LED-1:0] ledr,
  output logic             timer_irq,
  output logic             bus_err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  target_e          target;
  logic [AW-1:0]    ramIdx;
  logic [31:0]      ram [RAM_WORDS];
  logic [N_LED-1:0] led_q, led_d;
  logic             busErr_q, busErr_d;
  logic [31:0]      timerRdata;
  logic             timerFlag;

  assign target = decodeAddr(Memaddr, RAM_WORDS);
  assign ramIdx = Memaddr[AW+1:2];

  rv32i_mmio_timer #(
    .TICK_DIV (TICK_DIV)
  ) uTimer (
    .clk       (clk),
    .reset     (reset),
    .tcntWe_i  (Memwrite && (target == T_TCNT)),
    .tcmpWe_i  (Memwrite && (target == T_TCMP)),
    .tstatWe_i (Memwrite && (target == T_TSTAT)),
    .wdata_i   (MemWdata),
    .rdSel_i   (target),
    .rdata_o   (timerRdata),
    .flag_o    (timerFlag)
  );

  // RAM write port; contents survive reset, but reset still blocks a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset && Memwrite && (target == T_RAM)) begin
      ram[ramIdx] <= MemWdata;
    end
  end

  // Next-state for the LED register and the sticky unmapped-write flag.
  always_comb begin
    led_d    = led_q;
    busErr_d = busErr_q;
    if (Memwrite && (target == T_LED)) begin
      led_d = MemWdata[N_LED-1:0];
    end
    if (Memwrite && (target == T_NONE)) begin
      busErr_d = 1'b1;
    end
  end

  // LED and bus-error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q    <= '0;
      busErr_q <= 1'b0;
    end else begin
      led_q    <= led_d;
      busErr_q <= busErr_d;
    end
  end

  // Combinational read mux so the CPU can capture the value at the end of MEM.
  always_comb begin
    MemRdata = 32'h0000_0000;
    case (target)
      T_RAM:                  MemRdata = ram[ramIdx];
      T_LED:                  MemRdata = 32'(led_q);
      T_SW:                   MemRdata = 32'(sw);
      T_TCNT, T_TCMP, T_TSTAT: MemRdata = timerRdata;
      default:                MemRdata = 32'h0000_0000;
    endcase
  end

  assign ledr      = led_q;
  assign timer_irq = timerFlag;
  assign bus_err   = busErr_q;

endmodule

// File: tb/tb_rv32i_data_responder.sv
// Bench for rv32i_data_responder: directed table, timer corner sequences and a random run.
module tb_rv32i_data_responder;

  localparam logic [31:0] A_LED   = 32'hFFFF_0000;
  localparam logic [31:0] A_SW    = 32'hFFFF_0004;
  localparam logic [31:0] A_TCNT  = 32'hFFFF_0010;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_0014;
  localparam logic [31:0] A_TSTAT = 32'hFFFF_0018;

  logic        clk = 1'b0;
  logic        reset;
  logic        Memwrite;
  logic [31:0] Memaddr;
  logic [31:0] MemWdata;
  logic [9:0]  sw;

  logic [31:0] rdata1, rdata4;
  logic [9:0]  ledr1, ledr4;
  logic        irq1, irq4;
  logic        berr1, berr4;

  int total = 0;
  int bad   = 0;

  // Reference model state for the random run.
  logic [31:0] ramM [int];
  logic [9:0]  ledM;
  logic [31:0] tcntM;
  logic [31:0] tcmpM;
  logic        berrM;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [9:0]  sw;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Free-running system clock.
  always #5 clk = ~clk;

  rv32i_data_responder #(
    .RAM_WORDS (2048), .TICK_DIV (1), .N_LED (10), .N_SW (10)
  ) dut1 (
    .clk (clk), .reset (reset), .Memwrite (Memwrite), .Memaddr (Memaddr),
    .MemWdata (MemWdata), .MemRdata (rdata1), .sw (sw), .ledr (ledr1),
    .timer_irq (irq1), .bus_err (berr1)
  );

  rv32i_data_responder #(
    .RAM_WORDS (2048), .TICK_DIV (4), .N_LED (10), .N_SW (10)
  ) dut4 (
    .clk (clk), .reset (reset), .Memwrite (Memwrite), .Memaddr (Memaddr),
    .MemWdata (MemWdata), .MemRdata (rdata4), .sw (sw), .ledr (ledr4),
    .timer_irq (irq4), .bus_err (berr4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    Memwrite = we;
    Memaddr  = addr;
    MemWdata = wd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic modelMapped(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w < 32'h2000) || (w == A_LED) || (w == A_SW) || (w == A_TCNT) ||
           (w == A_TCMP) || (w == A_TSTAT);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h2000) return ramM[int'(w >> 2)];
    if (w == A_LED)   return {22'b0, ledM};
    if (w == A_SW)    return {22'b0, sw};
    if (w == A_TCNT)  return tcntM;
    if (w == A_TCMP)  return tcmpM;
    return 32'h0000_0000;
  endfunction

  function automatic logic [31:0] randUnmapped();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
      1:       a = 32'h0000_2000 + ($urandom_range(0, 1023) * 4);
      2:       a = 32'hFFFF_0008;
      default: a = 32'hFFFF_001C;
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] prev;
    logic        found;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    int          op;

    reset = 1'b1;
    sw    = '0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("rst_ledr", 32'(ledr1), 32'h0);
    checkOutput("rst_bus_err", 32'(berr1), 32'h0);
    checkOutput("rst_irq", 32'(irq1), 32'h0);

    // Directed vector table: {we, addr, wdata, sw, check, expected read (old value on writes)}.
    vecs.push_back('{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 10'h000, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0104, 32'h1234_5678, 10'h000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         10'h000, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0104, 32'h0,         10'h000, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b0, 32'h0000_0102, 32'h0,         10'h000, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, A_SW,          32'h0,         10'h2A5, 1'b1, 32'h0000_02A5});
    vecs.push_back('{1'b1, A_LED,         32'hFFFF_FFFF, 10'h2A5, 1'b1, 32'h0000_0000});
    vecs.push_back('{1'b0, A_LED,         32'h0,         10'h2A5, 1'b1, 32'h0000_03FF});
    vecs.push_back('{1'b1, A_SW,          32'h0000_0000, 10'h2A5, 1'b1, 32'h0000_02A5});
    vecs.push_back('{1'b0, A_SW,          32'h0,         10'h2A5, 1'b1, 32'h0000_02A5});
    vecs.push_back('{1'b1, 32'h0000_0104, 32'hAAAA_5555, 10'h000, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b0, 32'h0000_0104, 32'h0,         10'h000, 1'b1, 32'hAAAA_5555});
    vecs.push_back('{1'b0, A_TCMP,        32'h0,         10'h000, 1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, A_TSTAT,       32'h0,         10'h000, 1'b1, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'hFFFF_0008, 32'h0,         10'h000, 1'b1, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h0000_2000, 32'h0,         10'h000, 1'b1, 32'h0000_0000});

    foreach (vecs[i]) begin
      sw = vecs[i].sw;
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wd);
      #1;
      if (vecs[i].chk) checkOutput($sformatf("vec%0d_rdata", i), rdata1, vecs[i].exp);
      nextCycle();
    end
    applyStimulus(1'b0, A_LED, 32'h0);
    #1;
    checkOutput("led_out", 32'(ledr1), 32'h0000_03FF);
    checkOutput("sw_write_no_err", 32'(berr1), 32'h0);

    // Timer wrap and match with a tick every clock.
    applyStimulus(1'b1, A_TCMP, 32'h0000_0001);
    nextCycle();
    applyStimulus(1'b1, A_TCNT, 32'hFFFF_FFFE);
    nextCycle();
    applyStimulus(1'b0, A_TCNT, 32'h0);
    #1;
    checkOutput("wrap_c0", rdata1, 32'hFFFF_FFFE);
    nextCycle();
    checkOutput("wrap_c1", rdata1, 32'hFFFF_FFFF);
    nextCycle();
    checkOutput("wrap_c2", rdata1, 32'h0000_0000);
    nextCycle();
    checkOutput("wrap_c3", rdata1, 32'h0000_0001);
    checkOutput("irq_c3", 32'(irq1), 32'h0);
    nextCycle();
    checkOutput("irq_c4", 32'(irq1), 32'h1);

    // W1C clear racing a fresh match: the set must win.
    applyStimulus(1'b1, A_TCMP, 32'h0000_0020);
    nextCycle();
    applyStimulus(1'b1, A_TCNT, 32'h0000_001E);
    nextCycle();
    applyStimulus(1'b0, A_TCNT, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("race_tcnt", rdata1, 32'h0000_0020);
    checkOutput("race_irq_before", 32'(irq1), 32'h1);
    applyStimulus(1'b1, A_TSTAT, 32'h0000_0001);
    nextCycle();
    checkOutput("race_irq_after", 32'(irq1), 32'h1);
    applyStimulus(1'b1, A_TSTAT, 32'h0000_0001);
    nextCycle();
    applyStimulus(1'b0, A_TSTAT, 32'h0);
    #1;
    checkOutput("clr_irq", 32'(irq1), 32'h0);
    checkOutput("clr_tstat", rdata1, 32'h0);

    // Prescaled timer: find a tick, then write on the tick cycle and on a mid-period cycle.
    applyStimulus(1'b0, A_TCNT, 32'h0);
    #1;
    prev  = rdata4;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found) begin
        nextCycle();
        if (rdata4 != prev) found = 1'b1;
        prev = rdata4;
      end
    end
    checkOutput("t4_tick_seen", 32'(found), 32'h1);
    repeat (3) nextCycle();
    applyStimulus(1'b1, A_TCNT, 32'h0000_0100);
    nextCycle();
    applyStimulus(1'b0, A_TCNT, 32'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t4_hold_a%0d", k), rdata4, 32'h0000_0100);
      nextCycle();
    end
    checkOutput("t4_inc_a", rdata4, 32'h0000_0101);
    nextCycle();
    applyStimulus(1'b1, A_TCNT, 32'h0000_0200);
    nextCycle();
    applyStimulus(1'b0, A_TCNT, 32'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t4_hold_b%0d", k), rdata4, 32'h0000_0200);
      nextCycle();
    end
    checkOutput("t4_inc_b", rdata4, 32'h0000_0201);

    // Random run against the reference model.
    ledM  = 10'h3FF;
    berrM = berr1;
    tcmpM = 32'h0000_0020;
    applyStimulus(1'b1, A_TCNT, 32'h0000_5000);
    nextCycle();
    tcntM = 32'h0000_5000;
    for (int k = 0; k < 16; k++) begin
      wd = $urandom;
      applyStimulus(1'b1, 32'h0000_0200 + 32'(k * 4), wd);
      nextCycle();
      ramM[128 + k] = wd;
      tcntM = tcntM + 32'd1;
    end
    for (int n = 0; n < 400; n++) begin
      op   = $urandom_range(0, 9);
      sw   = 10'($urandom);
      we   = 1'b0;
      wd   = $urandom;
      addr = 32'h0000_0200 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      case (op)
        0: we = 1'b1;
        1: ;
        2: begin we = 1'b1; addr = A_LED; end
        3: addr = A_LED;
        4: addr = A_SW;
        5: begin we = 1'b1; addr = A_SW; end
        6: addr = A_TCNT;
        7: begin we = 1'b1; addr = A_TCNT; wd = wd | 32'h8000_0000; end
        8: begin we = 1'b1; addr = randUnmapped(); end
        default: addr = ($urandom_range(0, 1) == 0) ? randUnmapped() : A_TCMP;
      endcase
      applyStimulus(we, addr, wd);
      #1;
      checkOutput($sformatf("rnd%0d_rdata", n), rdata1, modelRead(addr));
      if (we) begin
        if ({addr[31:2], 2'b00} < 32'h2000) ramM[int'(addr >> 2)] = wd;
        if ({addr[31:2], 2'b00} == A_LED)   ledM = wd[9:0];
        if (!modelMapped(addr))             berrM = 1'b1;
      end
      tcntM = (we && ({addr[31:2], 2'b00} == A_TCNT)) ? wd : tcntM + 32'd1;
      nextCycle();
      checkOutput($sformatf("rnd%0d_ledr", n), 32'(ledr1), 32'(ledM));
      checkOutput($sformatf("rnd%0d_bus_err", n), 32'(berr1), 32'(berrM));
    end

    // Reset overriding a same-cycle write, then unmapped accesses.
    applyStimulus(1'b1, A_LED, 32'h0000_0155);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, A_TCMP, 32'h0);
    #1;
    checkOutput("rst2_ledr", 32'(ledr1), 32'h0);
    checkOutput("rst2_bus_err", 32'(berr1), 32'h0);
    checkOutput("rst2_tcmp", rdata1, 32'hFFFF_FFFF);
    checkOutput("rst2_irq", 32'(irq1), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0100, 32'h0);
    #1;
    checkOutput("rst2_ram_kept", rdata1, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(1'b0, 32'h8000_0000, 32'h0);
    #1;
    checkOutput("unm_read_data", rdata1, 32'h0);
    nextCycle();
    checkOutput("unm_read_no_err", 32'(berr1), 32'h0);
    applyStimulus(1'b1, 32'h8000_0000, 32'h0000_1234);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0000, 32'h0);
    #1;
    checkOutput("unm_write_err", 32'(berr1), 32'h1);
    nextCycle();
    checkOutput("unm_err_sticky", 32'(berr1), 32'h1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rst3_bus_err", 32'(berr1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
